mem_port_arbiter: RTL and testbench

// - Shares one memory port between the core's iBus (fetch) and dBus (load/store).
// - Arbitrates commands and holds each grant until the command is accepted.
// - Tracks outstanding reads in a tag FIFO and routes in-order responses to their owner.
// - Sits between the riscv core and the single-ported instruction/data memory.

---
 rtl/mem_port_arbiter_pkg.sv | 9 +
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter_tag_fifo.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD_I = 2'd1, HOLD_D = 2'd2} arb_state_t;
  typedef enum logic {SRC_I = 1'b0, SRC_D = 1'b1} arb_src_t;

  localparam logic [3:0] IBUS_MASK = 4'b1111;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - iBus/dBus/memory bundle; slave = arbiter side, master = core and memory side
interface mem_port_arbiter_if;

  logic        iBus_cmd_valid;
  logic        iBus_cmd_ready;
  logic [31:0] iBus_cmd_payload_pc;
  logic        iBus_rsp_ready;
  logic        iBus_rsp_err;
  logic [31:0] iBus_rsp_instr;

  logic        dBus_cmd_valid;
  logic        dBus_cmd_ready;
  logic [31:0] dBus_cmd_payload_addr;
  logic [31:0] dBus_cmd_payload_data;
  logic [3:0]  dBus_cmd_payload_size;
  logic        dBus_cmd_payload_wr;
  logic        dBus_rsp_valid;
  logic        dBus_rsp_error;
  logic [31:0] dBus_rsp_data;

  logic        mem_cmd_valid;
  logic        mem_cmd_ready;
  logic [31:0] mem_cmd_addr;
  logic [31:0] mem_cmd_data;
  logic [3:0]  mem_cmd_mask;
  logic        mem_cmd_wr;
  logic        mem_rsp_valid;
  logic        mem_rsp_error;
  logic [31:0] mem_rsp_data;

  modport slave (
    input  iBus_cmd_valid, iBus_cmd_payload_pc,
    output iBus_cmd_ready, iBus_rsp_ready, iBus_rsp_err, iBus_rsp_instr,
    input  dBus_cmd_valid, dBus_cmd_payload_addr, dBus_cmd_payload_data,
    input  dBus_cmd_payload_size, dBus_cmd_payload_wr,
    output dBus_cmd_ready, dBus_rsp_valid, dBus_rsp_error, dBus_rsp_data,
    output mem_cmd_valid, mem_cmd_addr, mem_cmd_data, mem_cmd_mask, mem_cmd_wr,
    input  mem_cmd_ready, mem_rsp_valid, mem_rsp_error, mem_rsp_data
  );

  modport master (
    output iBus_cmd_valid, iBus_cmd_payload_pc,
    input  iBus_cmd_ready, iBus_rsp_ready, iBus_rsp_err, iBus_rsp_instr,
    output dBus_cmd_valid, dBus_cmd_payload_addr, dBus_cmd_payload_data,
    output dBus_cmd_payload_size, dBus_cmd_payload_wr,
    input  dBus_cmd_ready, dBus_rsp_valid, dBus_rsp_error, dBus_rsp_data,
    input  mem_cmd_valid, mem_cmd_addr, mem_cmd_data, mem_cmd_mask, mem_cmd_wr,
    output mem_cmd_ready, mem_rsp_valid, mem_rsp_error, mem_rsp_data
  );

endinterface

// File: rtl/mem_port_arbiter_tag_fifo.sv
// rtl/mem_port_arbiter_tag_fifo.sv - arb_tag_fifo: in-order owner tags of outstanding reads
module arb_tag_fifo
  import mem_arb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  arb_src_t      push_data,
  input  logic          pop,
  output arb_src_t      pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  arb_src_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = pop & ~empty;
  // A pop frees the head slot in the same cycle, so a push into a full FIFO is allowed then.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between iBus and dBus with in-order response routing
// Optional iBus starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_OUTST    = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus,
  output logic                 err_unexpected_rsp
);

  localparam int CW = $clog2(MAX_OUTST) + 1;

  arb_state_t      state;
  arb_state_t      state_next;
  logic            grant_i;
  logic            grant_d;
  logic            force_i;
  logic            i_ok;
  logic            d_ok;
  logic            d_read;
  logic            pop;
  logic            read_block;
  logic            i_fire;
  logic            d_fire;
  logic            push;
  logic            tag_full;
  logic            tag_empty;
  logic [CW-1:0]   tag_count;
  arb_src_t        tag_head;

  assign d_read     = ~bus.dBus_cmd_payload_wr;
  assign pop        = bus.mem_rsp_valid & (tag_count != '0);
  assign read_block = tag_full & ~pop;
  assign i_ok       = bus.iBus_cmd_valid & ~read_block;
  assign d_ok       = bus.dBus_cmd_valid & ~(d_read & read_block);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_i & ~bus.mem_cmd_ready)      state_next = HOLD_I;
        else if (grant_d & ~bus.mem_cmd_ready) state_next = HOLD_D;
      end
      HOLD_I, HOLD_D: if (bus.mem_cmd_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state)
      HOLD_I: grant_i = 1'b1;
      HOLD_D: grant_d = 1'b1;
      default: begin
        grant_i = i_ok & (~d_ok | force_i);
        grant_d = d_ok & ~grant_i;
      end
    endcase
  end

  assign i_fire = grant_i & bus.mem_cmd_ready & ~read_block;
  assign d_fire = grant_d & bus.mem_cmd_ready & ~(d_read & read_block);
  assign push   = i_fire | (d_fire & d_read);

  assign bus.iBus_cmd_ready = i_fire;
  assign bus.dBus_cmd_ready = d_fire;
  assign bus.mem_cmd_valid  = grant_i | grant_d;
  assign bus.mem_cmd_addr   = grant_d ? bus.dBus_cmd_payload_addr : bus.iBus_cmd_payload_pc;
  assign bus.mem_cmd_data   = grant_d ? bus.dBus_cmd_payload_data : 32'h0;
  assign bus.mem_cmd_mask   = grant_d ? bus.dBus_cmd_payload_size : IBUS_MASK;
  assign bus.mem_cmd_wr     = grant_d & bus.dBus_cmd_payload_wr;

  arb_tag_fifo #(.DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (grant_d ? SRC_D : SRC_I),
    .pop       (pop),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  assign bus.iBus_rsp_ready = pop & (tag_head == SRC_I);
  assign bus.iBus_rsp_err   = bus.iBus_rsp_ready & bus.mem_rsp_error;
  assign bus.iBus_rsp_instr = bus.mem_rsp_data;
  assign bus.dBus_rsp_valid = pop & (tag_head == SRC_D);
  assign bus.dBus_rsp_error = bus.dBus_rsp_valid & bus.mem_rsp_error;
  assign bus.dBus_rsp_data  = bus.mem_rsp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    err_unexpected_rsp <= 1'b0;
    else if (bus.mem_rsp_valid & tag_empty)     err_unexpected_rsp <= 1'b1;
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int             SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;

  // Counts dBus wins while a fetch is waiting; saturates so the forced grant persists until iBus wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          starve_cnt <= '0;
    else if (i_fire | ~bus.iBus_cmd_valid)            starve_cnt <= '0;
    else if (d_fire && (starve_cnt != STARVE_MAX))    starve_cnt <= starve_cnt + 1'b1;
  end

  assign force_i = (starve_cnt == STARVE_MAX);
`else
  assign force_i = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int MAX_OUTST    = 4;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic err_unexpected_rsp;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MAX_OUTST(MAX_OUTST), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus),
    .err_unexpected_rsp (err_unexpected_rsp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state, expressed as transactions rather than RTL state.
  bit   tagq[$];
  int   held;
  int   starve;
  bit   err_m;
  byte  glog[$];

  bit   m_pop, m_full, m_iok, m_dok, m_frc, m_gi, m_gd, m_ri, m_rd, m_rspi, m_rspd;
  logic [7:0] m_flags, d_flags;

  always @(negedge clk) begin
    if (rst) begin
      tagq.delete();
      held   = 0;
      starve = 0;
      err_m  = 1'b0;
    end else begin
      m_pop  = bus.mem_rsp_valid && (tagq.size() > 0);
      m_full = (tagq.size() == MAX_OUTST) && !m_pop;
`ifdef MEM_ARB_STARVE_GUARD_EN
      m_frc  = (starve >= STARVE_LIMIT);
`else
      m_frc  = 1'b0;
`endif
      if (held == 1) begin
        m_gi = 1'b1; m_gd = 1'b0;
      end else if (held == 2) begin
        m_gi = 1'b0; m_gd = 1'b1;
      end else begin
        m_iok = bus.iBus_cmd_valid && !m_full;
        m_dok = bus.dBus_cmd_valid && (bus.dBus_cmd_payload_wr || !m_full);
        m_gi  = m_iok && (!m_dok || m_frc);
        m_gd  = m_dok && !m_gi;
      end
      m_ri   = m_gi && bus.mem_cmd_ready && !m_full;
      m_rd   = m_gd && bus.mem_cmd_ready && (bus.dBus_cmd_payload_wr || !m_full);
      m_rspi = m_pop && (tagq[0] == 1'b0);
      m_rspd = m_pop && (tagq[0] == 1'b1);

      m_flags = {m_gi | m_gd, m_ri, m_rd, m_rspi, m_rspi & bus.mem_rsp_error,
                 m_rspd, m_rspd & bus.mem_rsp_error, err_m};
      d_flags = {bus.mem_cmd_valid, bus.iBus_cmd_ready, bus.dBus_cmd_ready, bus.iBus_rsp_ready,
                 bus.iBus_rsp_err, bus.dBus_rsp_valid, bus.dBus_rsp_error, err_unexpected_rsp};
      check("model_flags", {56'h0, d_flags}, {56'h0, m_flags});
      if (m_gi || m_gd) begin
        check("model_addr_data", {bus.mem_cmd_addr, bus.mem_cmd_data},
              m_gd ? {bus.dBus_cmd_payload_addr, bus.dBus_cmd_payload_data}
                   : {bus.iBus_cmd_payload_pc, 32'h0});
        check("model_mask_wr", {59'h0, bus.mem_cmd_mask, bus.mem_cmd_wr},
              m_gd ? {59'h0, bus.dBus_cmd_payload_size, bus.dBus_cmd_payload_wr}
                   : {59'h0, 4'hF, 1'b0});
      end
      if (m_rspi) check("model_irsp_data", {32'h0, bus.iBus_rsp_instr}, {32'h0, bus.mem_rsp_data});
      if (m_rspd) check("model_drsp_data", {32'h0, bus.dBus_rsp_data}, {32'h0, bus.mem_rsp_data});

      if (bus.iBus_cmd_ready) glog.push_back("I");
      if (bus.dBus_cmd_ready) glog.push_back("D");

      if (bus.mem_rsp_valid && tagq.size() == 0) err_m = 1'b1;
      if (m_pop) void'(tagq.pop_front());
      if (m_ri) tagq.push_back(1'b0);
      if (m_rd && !bus.dBus_cmd_payload_wr) tagq.push_back(1'b1);
      held = (m_gi && !bus.mem_cmd_ready) ? 1 : (m_gd && !bus.mem_cmd_ready) ? 2 : 0;
      if (m_ri || !bus.iBus_cmd_valid) starve = 0;
      else if (m_rd && starve < STARVE_LIMIT) starve++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    bus.iBus_cmd_valid        = 1'b0;
    bus.iBus_cmd_payload_pc   = 32'h0;
    bus.dBus_cmd_valid        = 1'b0;
    bus.dBus_cmd_payload_addr = 32'h0;
    bus.dBus_cmd_payload_data = 32'h0;
    bus.dBus_cmd_payload_size = 4'h0;
    bus.dBus_cmd_payload_wr   = 1'b0;
    bus.mem_cmd_ready         = 1'b1;
    bus.mem_rsp_valid         = 1'b0;
    bus.mem_rsp_error         = 1'b0;
    bus.mem_rsp_data          = 32'h0;
  endtask

  logic [31:0] rsp_vals [3];
  byte         exp_g;

  initial begin
    clear_inputs();
    #1 rst = 1'b1;
    settle();
    check("reset_cmd_valid", bus.mem_cmd_valid, 1'b0);
    check("reset_err", err_unexpected_rsp, 1'b0);
    step(); step();
    rst = 1'b0;

    // iBus-only fetches, in-order responses
    rsp_vals[0] = 32'h13; rsp_vals[1] = 32'h93; rsp_vals[2] = 32'h33;
    for (int k = 0; k < 3; k++) begin
      step();
      bus.iBus_cmd_valid = 1'b1;
      bus.iBus_cmd_payload_pc = 32'(k * 4);
      settle();
      check("fetch_ready", bus.iBus_cmd_ready, 1'b1);
      check("fetch_mask", bus.mem_cmd_mask, 4'hF);
      check("fetch_addr", bus.mem_cmd_addr, 32'(k * 4));
    end
    step();
    bus.iBus_cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = rsp_vals[k];
      settle();
      check("fetch_rsp_valid", bus.iBus_rsp_ready, 1'b1);
      check("fetch_rsp_instr", bus.iBus_rsp_instr, rsp_vals[k]);
      check("fetch_rsp_no_d", bus.dBus_rsp_valid, 1'b0);
      step();
    end
    bus.mem_rsp_valid = 1'b0;

    // Simultaneous requests: dBus first
    bus.iBus_cmd_valid = 1'b1; bus.iBus_cmd_payload_pc = 32'h10;
    bus.dBus_cmd_valid = 1'b1; bus.dBus_cmd_payload_addr = 32'h100;
    bus.dBus_cmd_payload_wr = 1'b0; bus.dBus_cmd_payload_size = 4'hF;
    settle();
    check("prio_d_ready", bus.dBus_cmd_ready, 1'b1);
    check("prio_i_wait", bus.iBus_cmd_ready, 1'b0);
    check("prio_addr", bus.mem_cmd_addr, 32'h100);
    step();
    bus.dBus_cmd_valid = 1'b0;
    settle();
    check("prio_i_next", bus.iBus_cmd_ready, 1'b1);
    step();
    bus.iBus_cmd_valid = 1'b0;
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hAA; bus.mem_rsp_error = 1'b1;
    settle();
    check("route_d_valid", bus.dBus_rsp_valid, 1'b1);
    check("route_d_err", bus.dBus_rsp_error, 1'b1);
    check("route_d_data", bus.dBus_rsp_data, 32'hAA);
    check("route_d_no_i", bus.iBus_rsp_ready, 1'b0);
    step();
    bus.mem_rsp_data = 32'hBB; bus.mem_rsp_error = 1'b0;
    settle();
    check("route_i_valid", bus.iBus_rsp_ready, 1'b1);
    check("route_i_data", bus.iBus_rsp_instr, 32'hBB);
    step();
    bus.mem_rsp_valid = 1'b0;

    // Held store while memory stalls
    bus.dBus_cmd_valid = 1'b1; bus.dBus_cmd_payload_wr = 1'b1;
    bus.dBus_cmd_payload_addr = 32'h200; bus.dBus_cmd_payload_data = 32'hDEADBEEF;
    bus.dBus_cmd_payload_size = 4'h3; bus.mem_cmd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("hold_valid", bus.mem_cmd_valid, 1'b1);
      check("hold_addr", bus.mem_cmd_addr, 32'h200);
      check("hold_data", bus.mem_cmd_data, 32'hDEADBEEF);
      check("hold_wr_mask", {bus.mem_cmd_wr, bus.mem_cmd_mask}, 5'h13);
      check("hold_not_ready", bus.dBus_cmd_ready, 1'b0);
      step();
    end
    bus.mem_cmd_ready = 1'b1;
    settle();
    check("hold_release", bus.dBus_cmd_ready, 1'b1);
    step();
    bus.dBus_cmd_valid = 1'b0; bus.dBus_cmd_payload_wr = 1'b0;

    // Fill the tag FIFO with fetches
    for (int k = 0; k < MAX_OUTST; k++) begin
      bus.iBus_cmd_valid = 1'b1;
      bus.iBus_cmd_payload_pc = 32'h40 + 32'(k * 4);
      settle();
      check("fill_ready", bus.iBus_cmd_ready, 1'b1);
      step();
    end
    bus.iBus_cmd_payload_pc = 32'h50;
    settle();
    check("full_blocks_read", bus.iBus_cmd_ready, 1'b0);
    check("full_no_cmd", bus.mem_cmd_valid, 1'b0);
    step();
    bus.dBus_cmd_valid = 1'b1; bus.dBus_cmd_payload_wr = 1'b1;
    bus.dBus_cmd_payload_addr = 32'h300; bus.dBus_cmd_payload_data = 32'h55;
    settle();
    check("full_write_passes", bus.dBus_cmd_ready, 1'b1);
    step();
    bus.dBus_cmd_valid = 1'b0; bus.dBus_cmd_payload_wr = 1'b0;
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h11;
    settle();
    check("full_push_pop_ready", bus.iBus_cmd_ready, 1'b1);
    check("full_push_pop_rsp", bus.iBus_rsp_ready, 1'b1);
    step();
    bus.mem_rsp_valid = 1'b0; bus.iBus_cmd_payload_pc = 32'h54;
    settle();
    check("count_still_full", bus.iBus_cmd_ready, 1'b0);
    step();
    bus.iBus_cmd_valid = 1'b0;
    for (int k = 0; k < MAX_OUTST; k++) begin
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h21 + 32'(k);
      settle();
      check("drain_rsp", bus.iBus_rsp_ready, 1'b1);
      step();
    end

    // Response with nothing outstanding
    bus.mem_rsp_data = 32'h99;
    settle();
    check("unexp_no_i", bus.iBus_rsp_ready, 1'b0);
    check("unexp_no_d", bus.dBus_rsp_valid, 1'b0);
    step();
    bus.mem_rsp_valid = 1'b0;
    settle();
    check("unexp_err_set", err_unexpected_rsp, 1'b1);
    step(); step();
    check("unexp_err_sticky", err_unexpected_rsp, 1'b1);
    rst = 1'b1;
    settle();
    check("unexp_err_cleared", err_unexpected_rsp, 1'b0);
    step();
    rst = 1'b0;

    // Both buses always requesting
    bus.iBus_cmd_valid = 1'b1; bus.iBus_cmd_payload_pc = 32'h80;
    bus.dBus_cmd_valid = 1'b1; bus.dBus_cmd_payload_wr = 1'b1;
    bus.dBus_cmd_payload_addr = 32'h400; bus.dBus_cmd_payload_size = 4'hF;
    glog.delete();
    for (int k = 0; k < 10; k++) step();
    bus.iBus_cmd_valid = 1'b0; bus.dBus_cmd_valid = 1'b0; bus.dBus_cmd_payload_wr = 1'b0;
    check("grant_count", 64'(glog.size()), 64'd10);
    for (int k = 0; k < 10 && k < glog.size(); k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_g = (k % 5 == 4) ? "I" : "D";
`else
      exp_g = "D";
`endif
      check("grant_pattern", 64'(glog[k]), 64'(exp_g));
    end

    // Reset with a fetch in flight discards its tag
    step();
    bus.iBus_cmd_valid = 1'b1; bus.iBus_cmd_payload_pc = 32'h90;
    step();
    bus.iBus_cmd_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h77;
    settle();
    check("post_reset_no_rsp", bus.iBus_rsp_ready, 1'b0);
    step();
    bus.mem_rsp_valid = 1'b0;
    settle();
    check("post_reset_unexp", err_unexpected_rsp, 1'b1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
